// File: rtl/muxn_skid.sv
// muxn_skid: N-input select feeding a two-entry valid/ready skid buffer.
// Out-of-range selects return input 0 and are tagged with an oor bit.
module muxn_skid #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SELW-1:0]    s,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_oor,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           nstate;
    logic [WIDTH-1:0] sel_data;
    logic             sel_oor;
    logic [WIDTH-1:0] head_data;
    logic             head_oor;
    logic [WIDTH-1:0] skid_data;
    logic             skid_oor;
    logic             accept;
    logic             pop;
    logic             ld_head;
    logic             ld_skid;
    logic             head_from_skid;

    always_comb begin
        sel_data = d[WIDTH-1:0];
        for (int i = 1; i < N; i++) begin
            if (s == SELW'(i)) sel_data = d[i*WIDTH +: WIDTH];
        end
    end

    // A power-of-two N leaves no unused select codes.
    if (N == (1 << SELW)) begin : g_pow2
        assign sel_oor = 1'b0;
    end else begin : g_oor
        assign sel_oor = (s >= SELW'(N));
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= nstate;
    end

    always_comb begin
        nstate         = state;
        ld_head        = 1'b0;
        ld_skid        = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            nstate = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        nstate  = ONE;
                        ld_head = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        nstate  = TWO;
                        ld_skid = 1'b1;
                    end else if (accept && pop) begin
                        ld_head = 1'b1;
                    end else if (pop) begin
                        nstate = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        nstate         = ONE;
                        ld_head        = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: nstate = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_data <= '0;
            head_oor  <= 1'b0;
            skid_data <= '0;
            skid_oor  <= 1'b0;
        end else begin
            if (ld_head) begin
                head_data <= head_from_skid ? skid_data : sel_data;
                head_oor  <= head_from_skid ? skid_oor  : sel_oor;
            end
            if (ld_skid) begin
                skid_data <= sel_data;
                skid_oor  <= sel_oor;
            end
        end
    end

    assign out_data = head_data;
    assign out_oor  = head_oor;

endmodule

// File: tb/tb_muxn_skid.sv
// tb_muxn_skid: directed and random checks of muxn_skid against a queue model.
// A second instance with N=4 covers the power-of-two select case.
module tb_muxn_skid;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;

    logic [3*W-1:0] d3;
    logic [1:0]     s3;
    logic           iv3, ir3, fl3, ov3, or3, oo3;
    logic [W-1:0]   od3;

    logic [4*W-1:0] d4;
    logic [1:0]     s4;
    logic           iv4, ir4, fl4, ov4, or4, oo4;
    logic [W-1:0]   od4;

    int checks   = 0;
    int failures = 0;

    logic [W:0] q[$];
    logic [W-1:0] popped[$];

    muxn_skid #(.WIDTH(W), .N(3)) u3 (
        .clk(clk), .rst_n(rst_n), .d(d3), .s(s3),
        .in_valid(iv3), .in_ready(ir3), .flush(fl3),
        .out_data(od3), .out_oor(oo3), .out_valid(ov3), .out_ready(or3)
    );

    muxn_skid #(.WIDTH(W), .N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .d(d4), .s(s4),
        .in_valid(iv4), .in_ready(ir4), .flush(fl4),
        .out_data(od4), .out_oor(oo4), .out_valid(ov4), .out_ready(or4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_sel(input logic [3*W-1:0] dv,
                                           input logic [1:0] sv);
        logic [W-1:0] w[3];
        for (int i = 0; i < 3; i++) w[i] = dv[i*W +: W];
        if (int'(sv) < 3) return {1'b0, w[sv]};
        return {1'b1, w[0]};
    endfunction

    // One clock: advance the model with the inputs the DUT sees, then compare.
    task automatic tick();
        bit acc;
        bit pp;
        acc = iv3 && (q.size() < 2);
        pp  = (q.size() > 0) && or3;
        if (ov3 && or3) popped.push_back(od3);
        if (fl3) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(ref_sel(d3, s3));
        end
        @(posedge clk);
        #1;
        chk("m_valid", 64'(ov3), 64'(q.size() != 0));
        chk("m_ready", 64'(ir3), 64'(q.size() < 2));
        if (q.size() != 0) begin
            chk("m_data", 64'(od3), 64'(q[0][W-1:0]));
            chk("m_oor", 64'(oo3), 64'(q[0][W]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d3 = '0; s3 = '0; iv3 = 0; fl3 = 0; or3 = 0;
        d4 = '0; s4 = '0; iv4 = 0; fl4 = 0; or4 = 0;
        #1;
        chk("rst_valid", 64'(ov3), 64'(0));
        chk("rst_ready", 64'(ir3), 64'(1));
        chk("rst_data", 64'(od3), 64'(0));
        #1 rst_n = 1'b1;

        // streaming
        d3 = {32'h33, 32'h22, 32'h11};
        iv3 = 1; or3 = 1;
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] e;
            s3 = 2'(i % 3);
            e = 32'h11 * W'((i % 3) + 1);
            tick();
            chk("stream_data", 64'(od3), 64'(e));
            chk("stream_oor", 64'(oo3), 64'(0));
        end
        iv3 = 0;
        tick();
        chk("stream_drain", 64'(ov3), 64'(0));

        // out-of-range select
        d3 = {32'h3, 32'h2, 32'hDEAD};
        s3 = 2'd3; iv3 = 1;
        tick();
        chk("oor3_data", 64'(od3), 64'(32'hDEAD));
        chk("oor3_flag", 64'(oo3), 64'(1));
        iv3 = 0;
        tick();

        d4 = {32'hBEEF, 32'h3, 32'h2, 32'h1};
        s4 = 2'd3; iv4 = 1;
        @(posedge clk);
        #1;
        chk("n4_valid", 64'(ov4), 64'(1));
        chk("n4_data", 64'(od4), 64'(32'hBEEF));
        chk("n4_oor", 64'(oo4), 64'(0));
        iv4 = 0; or4 = 1;

        // back-pressure
        or3 = 0; iv3 = 1; s3 = 2'd0;
        popped.delete();
        d3 = {32'h0, 32'h0, 32'hA};
        tick();
        d3 = {32'h0, 32'h0, 32'hB};
        tick();
        d3 = {32'h0, 32'h0, 32'hC};
        chk("bp_ready_c", 64'(ir3), 64'(0));
        tick();
        chk("bp_head_a", 64'(od3), 64'(32'hA));
        or3 = 1;
        tick();
        tick();
        iv3 = 0;
        tick();
        chk("bp_count", 64'(popped.size()), 64'(3));
        if (popped.size() == 3) begin
            chk("bp_pop0", 64'(popped[0]), 64'(32'hA));
            chk("bp_pop1", 64'(popped[1]), 64'(32'hB));
            chk("bp_pop2", 64'(popped[2]), 64'(32'hC));
        end

        // flush in TWO with a concurrent offer
        or3 = 0; iv3 = 1;
        d3 = {32'h0, 32'h0, 32'h5};
        tick();
        tick();
        chk("fl_two", 64'(ir3), 64'(0));
        d3 = {32'h0, 32'h0, 32'hD};
        fl3 = 1;
        tick();
        fl3 = 0; iv3 = 0;
        chk("fl_valid", 64'(ov3), 64'(0));
        chk("fl_ready", 64'(ir3), 64'(1));
        or3 = 1;
        tick();
        chk("fl_no_d", 64'(ov3), 64'(0));

        // asynchronous reset while full
        or3 = 0; iv3 = 1;
        d3 = {32'h77, 32'h66, 32'h55};
        s3 = 2'd1;
        tick();
        s3 = 2'd3;
        tick();
        chk("ar_two", 64'(ir3), 64'(0));
        iv3 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(ov3), 64'(0));
        chk("ar_ready", 64'(ir3), 64'(1));
        chk("ar_data", 64'(od3), 64'(0));
        chk("ar_oor", 64'(oo3), 64'(0));
        q.delete();
        #1 rst_n = 1'b1;

        // random traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            d3  = {$urandom, $urandom, $urandom};
            s3  = 2'($urandom_range(0, 3));
            iv3 = 1'($urandom_range(0, 1));
            or3 = 1'($urandom_range(0, 1));
            fl3 = ($urandom_range(0, 99) < 2);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
